// File: rtl/voice_sched_pkg.sv
// Shared types and default sizing for the voice scheduler.
// The optional VOICE_STEAL_EN macro is consumed by voice_scheduler.sv.
package voice_sched_pkg;
    localparam int DEF_NUM_VOICES      = 3;
    localparam int DEF_NOTE_W          = 6;
    localparam int DEF_DUR_W           = 6;
    localparam int DEF_QUEUE_DEPTH     = 4;
    localparam int DEF_CONFIRM_TIMEOUT = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, CONFIRM} sched_state_e;

    typedef struct packed {
        logic [DEF_NOTE_W-1:0] note;
        logic [DEF_DUR_W-1:0]  duration;
    } note_req_t;
endpackage

// File: rtl/note_req_fifo.sv
// Pending note-request FIFO; head is read combinationally, a push into a
// full queue is accepted when a pop happens in the same cycle.
module note_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [W-1:0]           i_data,
    output logic [W-1:0]           o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          w_push, w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/voice_scheduler.sv
// Queues note requests and hands each to a free voice with a one-cycle load pulse.
// Define VOICE_STEAL_EN to let a full queue steal the least recently issued voice.
module voice_scheduler
    import voice_sched_pkg::*;
#(
    parameter int NUM_VOICES      = DEF_NUM_VOICES,
    parameter int NOTE_W          = DEF_NOTE_W,
    parameter int DUR_W           = DEF_DUR_W,
    parameter int QUEUE_DEPTH     = DEF_QUEUE_DEPTH,
    parameter int CONFIRM_TIMEOUT = DEF_CONFIRM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  play,
    input  logic                  load_new_note,
    input  logic [NOTE_W-1:0]     note_to_load,
    input  logic [DUR_W-1:0]      duration_to_load,
    input  logic [NUM_VOICES-1:0] voice_playing,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic                  queue_full,
    output logic [7:0]            dropped_count,
    output logic [3:0]            active_voices
);
    localparam int SEL_W = $clog2(NUM_VOICES);
    localparam int CNT_W = $clog2(CONFIRM_TIMEOUT + 1);
    localparam int QW    = $clog2(QUEUE_DEPTH) + 1;

    sched_state_e            r_state, w_next;
    logic [NUM_VOICES-1:0]   r_reserved, r_load, w_free, w_busy;
    logic [SEL_W-1:0]        r_sel, w_sel;
    logic                    w_sel_vld, w_confirm, w_pop, w_full, w_empty, w_drop;
    logic [CNT_W-1:0]        r_cnt;
    logic [QW-1:0]           w_count;
    logic [NOTE_W+DUR_W-1:0] w_head;
    logic [NOTE_W-1:0]       r_note;
    logic [DUR_W-1:0]        r_dur;
    logic [7:0]              r_dropped;
    logic [3:0]              w_active;

    note_req_fifo #(.DEPTH(QUEUE_DEPTH), .W(NOTE_W + DUR_W)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (load_new_note),
        .i_pop   (w_pop),
        .i_data  ({note_to_load, duration_to_load}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = (r_state == ISSUE);
    assign w_drop = load_new_note && w_full && !w_pop;
    assign w_free = ~voice_playing & ~r_reserved;
    assign w_busy = voice_playing | r_reserved;

    assign voice_load     = r_load;
    assign voice_note     = r_note;
    assign voice_duration = r_dur;
    assign queue_full     = (w_count == QW'(QUEUE_DEPTH));
    assign dropped_count  = r_dropped;
    assign active_voices  = w_active;

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) w_active = w_active + 4'(w_busy[i]);
    end

`ifdef VOICE_STEAL_EN
    logic [SEL_W-1:0] r_rank [NUM_VOICES];
    logic [SEL_W-1:0] w_best;
    logic             w_steal, r_stolen, r_play_d;
`endif

    // Lowest-index free voice wins; scanning downward leaves the lowest one selected.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_sel     = SEL_W'(i);
                w_sel_vld = 1'b1;
            end
        end
`ifdef VOICE_STEAL_EN
        w_steal = 1'b0;
        w_best  = '0;
        if (!w_sel_vld && queue_full) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!r_reserved[i] && (!w_steal || r_rank[i] > w_best)) begin
                    w_best  = r_rank[i];
                    w_sel   = SEL_W'(i);
                    w_steal = 1'b1;
                end
            end
            w_sel_vld = w_steal;
        end
        // A stolen voice is already playing, so only a fresh rise counts as confirmation.
        w_confirm = r_stolen ? (voice_playing[r_sel] && !r_play_d) : voice_playing[r_sel];
`else
        w_confirm = voice_playing[r_sel];
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_empty && play && w_sel_vld) w_next = ISSUE;
            ISSUE:   w_next = CONFIRM;
            CONFIRM: if (w_confirm || r_cnt == CNT_W'(CONFIRM_TIMEOUT - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_reserved <= '0;
            r_load     <= '0;
            r_note     <= '0;
            r_dur      <= '0;
            r_cnt      <= '0;
            r_dropped  <= '0;
        end else begin
            r_state <= w_next;
            r_load  <= '0;
            case (r_state)
                IDLE: if (w_next == ISSUE) r_sel <= w_sel;
                ISSUE: begin
                    r_load            <= NUM_VOICES'(1) << r_sel;
                    r_note            <= w_head[NOTE_W+DUR_W-1:DUR_W];
                    r_dur             <= w_head[DUR_W-1:0];
                    r_reserved[r_sel] <= 1'b1;
                    r_cnt             <= '0;
                end
                CONFIRM: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_next == IDLE) r_reserved[r_sel] <= 1'b0;
                end
                default: ;
            endcase
            if (w_drop && r_dropped != 8'hFF) r_dropped <= r_dropped + 1'b1;
        end
    end

`ifdef VOICE_STEAL_EN
    // Rank 0 = most recently issued; the highest rank is the steal victim.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) r_rank[i] <= SEL_W'(NUM_VOICES - 1 - i);
            r_stolen <= 1'b0;
            r_play_d <= 1'b0;
        end else begin
            r_play_d <= voice_playing[r_sel];
            if (r_state == IDLE && w_next == ISSUE) r_stolen <= w_steal;
            if (r_state == ISSUE) begin
                for (int i = 0; i < NUM_VOICES; i++)
                    if (r_rank[i] < r_rank[r_sel]) r_rank[i] <= r_rank[i] + 1'b1;
                r_rank[r_sel] <= '0;
            end
        end
    end
`endif
endmodule
